// File: rtl/seed_pkg.sv
// Shared constants and FSM encoding for the seed bit RAM and its write-side loader.
package seed_pkg;

  localparam int unsigned SEED_WORDS  = 256;
  localparam int unsigned SEED_ADDR_W = 8;
  localparam int unsigned SEED_DATA_W = 16;
  localparam int unsigned SEED_BITS   = 4096;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2,
    ST_VALID = 2'd3
  } seed_state_e;

endpackage

// File: rtl/seed_ram_loader.sv
// Write-side controller for the seed bit RAM: streams seed words into the RAM
// and blocks bit-reader reads while the seed is being rewritten.
module seed_ram_loader
  import seed_pkg::*;
#(
  parameter int unsigned WORDS  = SEED_WORDS,
  parameter int unsigned ADDR_W = SEED_ADDR_W,
  parameter int unsigned DATA_W = SEED_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  input  logic              rd_en,
  output logic              rd_en_gated,
  input  logic              rd_busy,
  output logic              seed_valid,
  output logic              load_done,
  output logic              busy,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  seed_state_e       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  eff_len_c;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              handshake_c;

  // Ready and read gating depend only on registered state, never on s_valid.
  assign s_ready       = (state_q == ST_LOAD) && (count_q < len_q);
  assign handshake_c   = s_valid && s_ready;
  assign rd_en_gated   = (state_q == ST_VALID) && rd_en;
  assign ram_wren      = wren_q;
  assign ram_wraddress = addr_q;
  assign ram_data      = data_q;
  assign load_done     = done_q;
  assign seed_valid    = valid_q;
  assign busy          = busy_q;
  assign word_count    = count_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      len_q   <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;

    // A length of zero or beyond the RAM depth means a full-depth load.
    if ((load_len == '0) || (load_len > CNT_W'(WORDS))) begin
      eff_len_c = CNT_W'(WORDS);
    end else begin
      eff_len_c = load_len;
    end

    case (state_q)
      ST_EMPTY: begin
        if (load_start) begin
          state_d = ST_LOAD;
          len_d   = eff_len_c;
          count_d = '0;
        end
      end
      ST_VALID: begin
        if (load_start) begin
          state_d = rd_busy ? ST_DRAIN : ST_LOAD;
          len_d   = eff_len_c;
          count_d = '0;
        end
      end
      ST_DRAIN: begin
        if (!rd_busy) begin
          state_d = ST_LOAD;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (handshake_c) begin
          wren_d  = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = s_data;
          count_d = count_q + CNT_W'(1);
          if ((count_q + CNT_W'(1)) == len_q) begin
            state_d = ST_VALID;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    valid_d = (state_d == ST_VALID);
    busy_d  = (state_d == ST_DRAIN) || (state_d == ST_LOAD);
  end

endmodule

// File: tb/tb_seed_ram_loader.sv
// Directed self-checking bench for seed_ram_loader.
module tb_seed_ram_loader;

  logic        clk_in;
  logic        rst;
  logic        load_start;
  logic [8:0]  load_len;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        ram_wren;
  logic [7:0]  ram_wraddress;
  logic [15:0] ram_data;
  logic        rd_en;
  logic        rd_en_gated;
  logic        rd_busy;
  logic        seed_valid;
  logic        load_done;
  logic        busy;
  logic [8:0]  word_count;

  int vectors;
  int miscompares;

  logic [15:0] pat [4] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0001};

  seed_ram_loader dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .load_start    (load_start),
    .load_len      (load_len),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .rd_en         (rd_en),
    .rd_en_gated   (rd_en_gated),
    .rd_busy       (rd_busy),
    .seed_valid    (seed_valid),
    .load_done     (load_done),
    .busy          (busy),
    .word_count    (word_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load_start = 1'b0; load_len = '0; s_valid = 1'b0; s_data = '0;
    rd_en = 1'b1; rd_busy = 1'b0;
    #3;
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready got %0h want 0", s_ready); end
    vectors++; if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL reset_wren got %0h want 0", ram_wren); end
    vectors++; if (ram_wraddress !== 8'h00) begin miscompares++; $display("FAIL reset_addr got %0h want 0", ram_wraddress); end
    vectors++; if (ram_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data got %0h want 0", ram_data); end
    vectors++; if (rd_en_gated !== 1'b0) begin miscompares++; $display("FAIL reset_rd_gated got %0h want 0", rd_en_gated); end
    vectors++; if (seed_valid !== 1'b0) begin miscompares++; $display("FAIL reset_seed_valid got %0h want 0", seed_valid); end
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL reset_load_done got %0h want 0", load_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0h want 0", busy); end
    vectors++; if (word_count !== 9'd0) begin miscompares++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    step();
    rst = 1'b1;
    step();
    vectors++; if (rd_en_gated !== 1'b0) begin miscompares++; $display("FAIL empty_rd_gated got %0h want 0", rd_en_gated); end
    rd_en = 1'b0;
  endtask

  task automatic test_full_load();
    load_start = 1'b1; load_len = 9'd0;
    step();
    load_start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL full_busy got %0h want 1", busy); end
    for (int i = 0; i < 256; i++) begin
      vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL full_s_ready[%0d] got %0h want 1", i, s_ready); end
      s_valid = 1'b1; s_data = 16'(i);
      step();
      vectors++; if (ram_wren !== 1'b1) begin miscompares++; $display("FAIL full_wren[%0d] got %0h want 1", i, ram_wren); end
      vectors++; if (ram_wraddress !== 8'(i)) begin miscompares++; $display("FAIL full_addr[%0d] got %0h want %0h", i, ram_wraddress, 8'(i)); end
      vectors++; if (ram_data !== 16'(i)) begin miscompares++; $display("FAIL full_data[%0d] got %0h want %0h", i, ram_data, 16'(i)); end
      vectors++; if (load_done !== (i == 255)) begin miscompares++; $display("FAIL full_done[%0d] got %0h want %0h", i, load_done, (i == 255)); end
      vectors++; if (seed_valid !== (i == 255)) begin miscompares++; $display("FAIL full_valid[%0d] got %0h want %0h", i, seed_valid, (i == 255)); end
    end
    s_valid = 1'b0;
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL full_s_ready_end got %0h want 0", s_ready); end
    step();
    vectors++; if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL full_wren_end got %0h want 0", ram_wren); end
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL full_done_end got %0h want 0", load_done); end
    vectors++; if (seed_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid_end got %0h want 1", seed_valid); end
    vectors++; if (word_count !== 9'd256) begin miscompares++; $display("FAIL full_count got %0d want 256", word_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_end got %0h want 0", busy); end
  endtask

  task automatic test_partial_toggle();
    load_start = 1'b1; load_len = 9'd4;
    step();
    load_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vectors++; if (s_ready !== (k < 7)) begin miscompares++; $display("FAIL part_s_ready[%0d] got %0h want %0h", k, s_ready, (k < 7)); end
      s_valid = ((k % 2) == 0);
      s_data  = ((k % 2) == 0) ? pat[k/2] : 16'hDEAD;
      step();
      vectors++; if (ram_wren !== ((k % 2) == 0)) begin miscompares++; $display("FAIL part_wren[%0d] got %0h want %0h", k, ram_wren, ((k % 2) == 0)); end
      if ((k % 2) == 0) begin
        vectors++; if (ram_wraddress !== 8'(k/2)) begin miscompares++; $display("FAIL part_addr[%0d] got %0h want %0h", k, ram_wraddress, 8'(k/2)); end
        vectors++; if (ram_data !== pat[k/2]) begin miscompares++; $display("FAIL part_data[%0d] got %0h want %0h", k, ram_data, pat[k/2]); end
      end
      vectors++; if (load_done !== (k == 6)) begin miscompares++; $display("FAIL part_done[%0d] got %0h want %0h", k, load_done, (k == 6)); end
    end
    vectors++; if (word_count !== 9'd4) begin miscompares++; $display("FAIL part_count got %0d want 4", word_count); end
    vectors++; if (seed_valid !== 1'b1) begin miscompares++; $display("FAIL part_valid got %0h want 1", seed_valid); end
    s_valid = 1'b1; s_data = 16'hBEEF;
    step();
    vectors++; if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL part_stray_wren got %0h want 0", ram_wren); end
    vectors++; if (word_count !== 9'd4) begin miscompares++; $display("FAIL part_stray_count got %0d want 4", word_count); end
    s_valid = 1'b0;
  endtask

  task automatic test_drain();
    rd_en = 1'b1; rd_busy = 1'b1;
    #1;
    vectors++; if (rd_en_gated !== 1'b1) begin miscompares++; $display("FAIL drain_pre_gated got %0h want 1", rd_en_gated); end
    load_start = 1'b1; load_len = 9'd2;
    step();
    load_start = 1'b0;
    vectors++; if (rd_en_gated !== 1'b0) begin miscompares++; $display("FAIL drain_gated got %0h want 0", rd_en_gated); end
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL drain_s_ready got %0h want 0", s_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL drain_busy got %0h want 1", busy); end
    vectors++; if (seed_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid got %0h want 0", seed_valid); end
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL drain_wait_s_ready[%0d] got %0h want 0", c, s_ready); end
      vectors++; if (rd_en_gated !== 1'b0) begin miscompares++; $display("FAIL drain_wait_gated[%0d] got %0h want 0", c, rd_en_gated); end
    end
    rd_busy = 1'b0;
    step();
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL drain_release_s_ready got %0h want 1", s_ready); end
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = (i == 0) ? 16'h1111 : 16'h2222;
      step();
      vectors++; if (ram_wraddress !== 8'(i)) begin miscompares++; $display("FAIL drain_addr[%0d] got %0h want %0h", i, ram_wraddress, 8'(i)); end
      vectors++; if (rd_en_gated !== (i == 1)) begin miscompares++; $display("FAIL drain_load_gated[%0d] got %0h want %0h", i, rd_en_gated, (i == 1)); end
      vectors++; if (load_done !== (i == 1)) begin miscompares++; $display("FAIL drain_done[%0d] got %0h want %0h", i, load_done, (i == 1)); end
    end
    s_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_ignored_restart();
    load_start = 1'b1; load_len = 9'd16;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 16'h0100 + 16'(i);
      if (i == 10) begin load_start = 1'b1; load_len = 9'd3; end
      step();
      load_start = 1'b0;
      vectors++; if (ram_wren !== 1'b1) begin miscompares++; $display("FAIL restart_wren[%0d] got %0h want 1", i, ram_wren); end
      vectors++; if (ram_wraddress !== 8'(i)) begin miscompares++; $display("FAIL restart_addr[%0d] got %0h want %0h", i, ram_wraddress, 8'(i)); end
      vectors++; if (load_done !== (i == 15)) begin miscompares++; $display("FAIL restart_done[%0d] got %0h want %0h", i, load_done, (i == 15)); end
    end
    s_valid = 1'b0;
    step();
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL restart_done_end got %0h want 0", load_done); end
    vectors++; if (word_count !== 9'd16) begin miscompares++; $display("FAIL restart_count got %0d want 16", word_count); end
    vectors++; if (seed_valid !== 1'b1) begin miscompares++; $display("FAIL restart_valid got %0h want 1", seed_valid); end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1; load_len = 9'd0;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_data = 16'hC000 + 16'(i);
      step();
    end
    rd_en = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL mid_s_ready got %0h want 0", s_ready); end
    vectors++; if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL mid_wren got %0h want 0", ram_wren); end
    vectors++; if (ram_wraddress !== 8'h00) begin miscompares++; $display("FAIL mid_addr got %0h want 0", ram_wraddress); end
    vectors++; if (ram_data !== 16'h0000) begin miscompares++; $display("FAIL mid_data got %0h want 0", ram_data); end
    vectors++; if (rd_en_gated !== 1'b0) begin miscompares++; $display("FAIL mid_rd_gated got %0h want 0", rd_en_gated); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %0h want 0", busy); end
    vectors++; if (word_count !== 9'd0) begin miscompares++; $display("FAIL mid_count got %0d want 0", word_count); end
    vectors++; if (seed_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %0h want 0", seed_valid); end
    s_valid = 1'b0;
    step();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++; if (seed_valid !== 1'b0) begin miscompares++; $display("FAIL post_valid[%0d] got %0h want 0", c, seed_valid); end
      vectors++; if (rd_en_gated !== 1'b0) begin miscompares++; $display("FAIL post_gated[%0d] got %0h want 0", c, rd_en_gated); end
    end
    load_start = 1'b1; load_len = 9'd0;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1; s_data = ~16'(i);
      step();
      vectors++; if (seed_valid !== (i == 255)) begin miscompares++; $display("FAIL reload_valid[%0d] got %0h want %0h", i, seed_valid, (i == 255)); end
      vectors++; if (rd_en_gated !== (i == 255)) begin miscompares++; $display("FAIL reload_gated[%0d] got %0h want %0h", i, rd_en_gated, (i == 255)); end
      vectors++; if (ram_data !== ~16'(i)) begin miscompares++; $display("FAIL reload_data[%0d] got %0h want %0h", i, ram_data, ~16'(i)); end
    end
    s_valid = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_full_load();
    test_partial_toggle();
    test_drain();
    test_ignored_restart();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seed_ram_loader.md
# seed_ram_loader

Write-side controller for the 4096×1 seed bit RAM. It accepts 16-bit seed words from an upstream source over a valid/ready stream. It sequences them into RAM word addresses 0..N-1, and gates the bit-reader's read enable so the Toeplitz bit stream is never read while the seed is being rewritten. It sits between the seed source and the existing RAM/bit-readout pair and drives the RAM write port, which is otherwise tied off.

## Interface
- `WORDS`, default 256: RAM depth in 16-bit words.
- `ADDR_W`, default 8: word address width, equal to clog2(WORDS).
- `DATA_W`, default 16: write data width.

- `clk_in` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `load_start` in 1: one-cycle request to (re)load the seed.
- `load_len` in ADDR_W+1: number of words to load, sampled on accepted `load_start`. 0 or >WORDS means WORDS.
- `s_valid` in 1: upstream word valid.
- `s_data` in DATA_W: upstream seed word.
- `s_ready` out 1: controller accepts the word this cycle.
- `ram_wren` out 1: RAM write enable.
- `ram_wraddress` out ADDR_W: RAM word address.
- `ram_data` out DATA_W: RAM write data.
- `rd_en` in 1: consumer read request.
- `rd_en_gated` out 1: read enable forwarded to the bit reader.
- `rd_busy` in 1: bit reader has a read sequence in flight.
- `seed_valid` out 1: RAM holds a complete seed.
- `load_done` out 1: one-cycle pulse when a load completes.
- `busy` out 1: high in DRAIN or LOAD.
- `word_count` out ADDR_W+1: words written in the current or last load.

## Operation
- FSM states: EMPTY, DRAIN, LOAD, VALID. Encoding constants live in the package.
- EMPTY:
  - `load_start` → LOAD.
  - `rd_en_gated` = 0.
- VALID:
  - `rd_en_gated` = `rd_en`.
  - `load_start` with `rd_busy`=1 → DRAIN.
  - `load_start` with `rd_busy`=0 → LOAD.
  - `seed_valid` drops in the cycle the transition is taken.
- DRAIN:
  - `rd_en_gated` = 0 (no new reads).
  - Waits for `rd_busy`=0, then → LOAD.
- LOAD:
  - `s_ready` = 1 while `word_count` < latched length.
  - Each handshake (`s_valid` & `s_ready`) writes `s_data` at address `word_count`, then increments `word_count`.
  - After the handshake of the final word → VALID.
- Entering LOAD clears `word_count` to 0 and latches the effective length.
- `load_start` in DRAIN or LOAD is ignored. No restart, no queued request.
- `s_valid` outside LOAD is ignored; `s_ready` = 0 there.
- `word_count` saturates at the latched length and never wraps. The address is `word_count[ADDR_W-1:0]`, so the maximum address is WORDS-1.
- Reset mid-load: state → EMPTY, `seed_valid` = 0. Partially written RAM contents are treated as invalid.

## Timing
- Reset values:
  - state = EMPTY.
  - `s_ready`, `ram_wren`, `rd_en_gated`, `seed_valid`, `load_done`, `busy` = 0.
  - `ram_wraddress`, `ram_data`, `word_count` = 0.
- `ram_wren`, `ram_wraddress` and `ram_data` are registered. A handshake at cycle n produces the write at cycle n+1 with the address and data of that word.
- `ram_wren` is high exactly one cycle per accepted word.
- `load_done` pulses at cycle n+1 after the final handshake at cycle n, coincident with the last `ram_wren`. `seed_valid` rises in the same cycle.
- `rd_en_gated` is combinational from `rd_en` and the registered state, with zero added latency.
- `s_ready` is driven from registered state and count only; no combinational path from `s_valid`.
- `load_start` → LOAD: `s_ready` first high one cycle after `load_start` when starting from EMPTY/VALID with `rd_busy`=0. From DRAIN, it is first high one cycle after `rd_busy` is sampled low.
- Back-to-back words: one word per cycle sustained.

## Structure
- Shared package `seed_pkg` holds:
  - the FSM state typedef/localparams;
  - `SEED_WORDS`=256, `SEED_ADDR_W`=8, `SEED_DATA_W`=16, `SEED_BITS`=4096.
- Single flat module, no sub-module. The write-port register stage is inline.
- Instantiated inside the bit generator wrapper next to the RAM and readout. It replaces the tie-offs of `wren`, `wraddress` and `data`.

## Test plan
- Reset, then `load_start` with `load_len`=0 and 256 words 0x0000..0x00FF on consecutive cycles:
  - 256 `ram_wren` pulses, addresses 0..255 with data equal to the address;
  - `load_done` once, in the cycle of the write to 0xFF;
  - `seed_valid`=1 thereafter.
- `load_len`=4 with `s_valid` toggling every other cycle, words 0xA5A5, 0x5A5A, 0xFFFF, 0x0001:
  - writes to addresses 0..3 only;
  - `s_ready` falls after the 4th handshake;
  - `word_count`=4.
- In VALID, `rd_en`=1 and `rd_busy`=1, then `load_start`:
  - → DRAIN, `rd_en_gated`=0 immediately, `s_ready`=0;
  - `rd_busy` dropped 5 cycles later → `s_ready` high the following cycle.
- `load_start` pulsed again mid-load at word 10 of 16:
  - ignored, load finishes at 16 words with a single `load_done`.
- Assert `rst` low at word 100 of 256:
  - all outputs zero asynchronously;
  - after release, `seed_valid`=0 and `rd_en_gated`=0 until a new full load completes.
